// File: rtl/note_scroller_pkg.sv
// Shared constants, note-register type and FSM encoding for the note scroller.
package note_scroller_pkg;
    localparam int ROWS       = 360;
    localparam int LANES      = 4;
    localparam int STEP_DEF   = 2;
    localparam int HIT_LO_DEF = 340;
    localparam int HIT_HI_DEF = 359;
    localparam int UCNT_W     = 16;

    typedef logic [LANES-1:0][ROWS-1:0] nreg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;
endpackage

// File: rtl/note_scroller_hit_resolver.sv
// One-lane strike resolver: finds the lowest-on-screen note inside the hit window and clears it.
module hit_resolver
    import note_scroller_pkg::*;
#(
    parameter int HIT_LO = HIT_LO_DEF,
    parameter int HIT_HI = HIT_HI_DEF
) (
    input  logic [ROWS-1:0] lane_i,
    input  logic            en_i,
    output logic [ROWS-1:0] lane_o,
    output logic            hit_o,
    output logic            bad_o
);
    logic            found;
    logic [ROWS-1:0] clr;

    // Scan from the bottom of the window up so only the highest-index note is taken.
    always_comb begin
        found = 1'b0;
        clr   = '0;
        for (int r = HIT_HI; r >= HIT_LO; r--) begin
            if (lane_i[r] && !found) begin
                found  = 1'b1;
                clr[r] = 1'b1;
            end
        end
        lane_o = en_i ? (lane_i & ~clr) : lane_i;
        hit_o  = en_i && found;
        bad_o  = en_i && !found;
    end
endmodule

// File: rtl/note_scroller.sv
// Per-frame scroller for the 4-lane note register with chart intake and strike resolution.
// Optional UNDERRUN_COUNT_EN adds underrun_cnt_o, a saturating count of starved shift cycles.
module note_scroller
    import note_scroller_pkg::*;
#(
    parameter int STEP   = STEP_DEF,
    parameter int HIT_LO = HIT_LO_DEF,
    parameter int HIT_HI = HIT_HI_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        frame_tick_i,
    input  logic                        run_i,
    input  logic                        chart_valid_i,
    input  logic [LANES-1:0]            chart_row_i,
    input  logic                        chart_last_i,
    output logic                        chart_ready_o,
    input  logic [LANES-1:0]            press_i,
    output logic [LANES-1:0][ROWS-1:0]  n_reg_o,
    output logic [LANES-1:0]            hit_o,
    output logic [LANES-1:0]            bad_o,
    output logic [LANES-1:0]            miss_o,
    output logic                        busy_o,
    output logic                        done_o
`ifdef UNDERRUN_COUNT_EN
    ,
    output logic [UCNT_W-1:0]           underrun_cnt_o
`endif
);
    state_t           state_q;
    logic [3:0]       step_q;
    nreg_t            n_reg_q;
    logic [LANES-1:0] pend_q, hit_q, bad_q, miss_q;
    logic             end_q, busy_q, done_q;

    nreg_t            resolved;
    logic [LANES-1:0] res_hit, res_bad, in_bit;
    logic             resolve_en, shift_en, accept;

    assign resolve_en    = (state_q == S_WAIT) && run_i;
    assign shift_en      = (state_q == S_SHIFT) && run_i;
    // Ready is withheld while paused so no chart row is consumed without a shift.
    assign chart_ready_o = shift_en && !end_q;
    assign accept        = chart_ready_o && chart_valid_i;
    assign in_bit        = accept ? chart_row_i : '0;

    for (genvar f = 0; f < LANES; f++) begin : g_lane
        hit_resolver #(
            .HIT_LO (HIT_LO),
            .HIT_HI (HIT_HI)
        ) u_res (
            .lane_i (n_reg_q[f]),
            .en_i   (resolve_en && pend_q[f]),
            .lane_o (resolved[f]),
            .hit_o  (res_hit[f]),
            .bad_o  (res_bad[f])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            n_reg_q <= '0;
            pend_q  <= '0;
            hit_q   <= '0;
            bad_q   <= '0;
            miss_q  <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            hit_q  <= '0;
            bad_q  <= '0;
            miss_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (run_i) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (run_i) begin
                        n_reg_q <= resolved;
                        hit_q   <= res_hit;
                        bad_q   <= res_bad;
                        pend_q  <= press_i;
                        if (end_q && n_reg_q == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (frame_tick_i) begin
                            state_q <= S_SHIFT;
                            step_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (run_i) begin
                        for (int l = 0; l < LANES; l++) begin
                            n_reg_q[l] <= {n_reg_q[l][ROWS-2:0], in_bit[l]};
                            miss_q[l]  <= n_reg_q[l][ROWS-1];
                        end
                        pend_q <= pend_q | press_i;
                        if (accept && chart_last_i) end_q <= 1'b1;
                        step_q <= step_q + 4'd1;
                        if (step_q == 4'(STEP - 1)) begin
                            state_q <= S_WAIT;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (!run_i) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        end_q   <= 1'b0;
                        pend_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UNDERRUN_COUNT_EN
    logic [UCNT_W-1:0] ucnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ucnt_q <= '0;
        end else if (state_q == S_DONE && !run_i) begin
            ucnt_q <= '0;
        end else if (chart_ready_o && !chart_valid_i && ucnt_q != '1) begin
            ucnt_q <= ucnt_q + 1'b1;
        end
    end

    assign underrun_cnt_o = ucnt_q;
`endif

    assign n_reg_o = n_reg_q;
    assign hit_o   = hit_q;
    assign bad_o   = bad_q;
    assign miss_o  = miss_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller: queue-of-positions reference model compared every cycle, plus directed checks.
module tb_note_scroller;
    import note_scroller_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_tick = 1'b0, run = 1'b0, chart_valid = 1'b0, chart_last = 1'b0;
    logic [LANES-1:0] chart_row = '0, press = '0;
    logic             chart_ready, busy, done;
    nreg_t            n_reg;
    logic [LANES-1:0] hit, bad, miss;
`ifdef UNDERRUN_COUNT_EN
    logic [UCNT_W-1:0] ucnt;
`endif

    always #5 clk = ~clk;

    note_scroller dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_tick_i  (frame_tick),
        .run_i         (run),
        .chart_valid_i (chart_valid),
        .chart_row_i   (chart_row),
        .chart_last_i  (chart_last),
        .chart_ready_o (chart_ready),
        .press_i       (press),
        .n_reg_o       (n_reg),
        .hit_o         (hit),
        .bad_o         (bad),
        .miss_o        (miss),
        .busy_o        (busy),
        .done_o        (done)
`ifdef UNDERRUN_COUNT_EN
        ,
        .underrun_cnt_o(ucnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each lane is a list of note row positions.
    int         m_state = 0;   // 0 idle, 1 wait, 2 shift, 3 done
    int         m_step  = 0;
    int         q[LANES][$];
    logic [3:0] m_pend = '0, m_hit = '0, m_bad = '0, m_miss = '0;
    bit         m_end  = 0;
    int         m_ucnt = 0;

    function automatic bit model_empty();
        for (int f = 0; f < LANES; f++) if (q[f].size() != 0) return 0;
        return 1;
    endfunction

    function automatic nreg_t exp_nreg();
        nreg_t v = '0;
        for (int f = 0; f < LANES; f++)
            for (int i = 0; i < q[f].size(); i++) v[f][q[f][i]] = 1'b1;
        return v;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_state = 0; m_step = 0; m_pend = '0; m_hit = '0; m_bad = '0; m_miss = '0;
            m_end = 0; m_ucnt = 0;
            for (int f = 0; f < LANES; f++) q[f].delete();
        end else begin
            m_hit = '0; m_bad = '0; m_miss = '0;
            case (m_state)
                0: if (run) m_state = 1;
                1: if (run) begin
                    bit was_empty;
                    was_empty = model_empty();
                    for (int f = 0; f < LANES; f++) begin
                        if (m_pend[f]) begin
                            int best, bi;
                            best = -1; bi = -1;
                            for (int i = 0; i < q[f].size(); i++)
                                if (q[f][i] >= HIT_LO_DEF && q[f][i] <= HIT_HI_DEF && q[f][i] > best) begin
                                    best = q[f][i]; bi = i;
                                end
                            if (bi >= 0) begin q[f].delete(bi); m_hit[f] = 1'b1; end
                            else m_bad[f] = 1'b1;
                        end
                    end
                    m_pend = press;
                    if (m_end && was_empty) m_state = 3;
                    else if (frame_tick) begin m_state = 2; m_step = 0; end
                end
                2: if (run) begin
                    bit acc;
                    acc = !m_end && chart_valid;
                    if (!m_end && !chart_valid && m_ucnt < 65535) m_ucnt++;
                    m_pend = m_pend | press;
                    for (int f = 0; f < LANES; f++) begin
                        int nq[$];
                        nq = {};
                        for (int i = 0; i < q[f].size(); i++) begin
                            if (q[f][i] + 1 >= ROWS) m_miss[f] = 1'b1;
                            else nq.push_back(q[f][i] + 1);
                        end
                        if (acc && chart_row[f]) nq.push_back(0);
                        q[f] = nq;
                    end
                    if (acc && chart_last) m_end = 1;
                    m_step++;
                    if (m_step == STEP_DEF) m_state = 1;
                end
                3: if (!run) begin m_state = 0; m_end = 0; m_pend = '0; m_ucnt = 0; end
                default: m_state = 0;
            endcase
        end
    end

    task automatic compare_all();
        nreg_t e;
        bit shown;
        e = exp_nreg();
        shown = 0;
        checks++;
        if (n_reg !== e) begin
            errors++;
            for (int f = 0; f < LANES; f++)
                for (int r = 0; r < ROWS; r++)
                    if (!shown && n_reg[f][r] !== e[f][r]) begin
                        $display("FAIL n_reg lane %0d row %0d: got %b expected %b", f, r, n_reg[f][r], e[f][r]);
                        shown = 1;
                    end
        end
        chk("chart_ready", 32'(chart_ready), 32'(m_state == 2 && !m_end && run));
        chk("hit", 32'(hit), 32'(m_hit));
        chk("bad", 32'(bad), 32'(m_bad));
        chk("miss", 32'(miss), 32'(m_miss));
        chk("busy", 32'(busy), 32'(m_state == 2));
        chk("done", 32'(done), 32'(m_state == 3));
`ifdef UNDERRUN_COUNT_EN
        chk("underrun_cnt", 32'(ucnt), 32'(m_ucnt));
`endif
    endtask

    bit cmp_en = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en && !rst) compare_all();
    end

    int         tick_no = 0, miss0_cnt = 0, miss0_tick = -1;
    logic [3:0] first_miss = '0;
    bit         first_seen = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en && !rst) begin
            if (miss[0]) begin miss0_cnt++; miss0_tick = tick_no; end
            if (miss != '0 && !first_seen) begin first_miss = miss; first_seen = 1; end
        end
    end

    // Issues one frame tick from WAIT and drives the two shift cycles; returns observed ready.
    task automatic do_tick(input logic [3:0] r1, input logic v1, input logic l1,
                           input logic [3:0] r2, input logic v2, input logic l2,
                           output logic rd1, output logic rd2);
        tick_no++;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0; chart_row = r1; chart_valid = v1; chart_last = l1;
        @(negedge clk); rd1 = chart_ready;
        @(posedge clk); #1;
        chart_row = r2; chart_valid = v2; chart_last = l2;
        @(negedge clk); rd2 = chart_ready;
        @(posedge clk); #1;
        chart_row = '0; chart_valid = 1'b0; chart_last = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd1, rd2;
        int   n;
`ifdef UNDERRUN_COUNT_EN
        logic [UCNT_W-1:0] u0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_nreg", 32'(|n_reg), 32'd0);
        chk("rst_ready", 32'(chart_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pulses", 32'({hit, bad, miss}), 32'd0);
        cmp_en = 1;

        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1;

        // Lane 0 enters on the first shift, lanes 2/3 on the second.
        do_tick(4'b0001, 1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, rd1, rd2);
        chk("ready_shift1", 32'(rd1), 32'd1);
        chk("ready_shift2", 32'(rd2), 32'd1);
        @(negedge clk);
        chk("lane3_top", 32'(n_reg[3][1:0]), 32'b01);
        chk("lane0_top", 32'(n_reg[0][1:0]), 32'b10);
        chk("busy_after_tick", 32'(busy), 32'd0);
`ifdef UNDERRUN_COUNT_EN
        chk("underrun_none", 32'(ucnt), 32'd0);
        u0 = ucnt;
`endif
        tick_no = 0;
        for (int k = 0; k < 175; k++) do_tick('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, rd1, rd2);
`ifdef UNDERRUN_COUNT_EN
        chk("underrun_total", 32'(ucnt - u0), 32'(175 * STEP_DEF));
`endif
        @(negedge clk);
        chk("lane2_at_350", 32'(n_reg[2][350]), 32'd1);

        @(posedge clk); #1 press = 4'b0100;
        @(posedge clk); #1 press = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hit_lane2", 32'(hit), 32'b0100);
        chk("hit_no_bad", 32'(bad), 32'd0);
        chk("lane2_cleared", 32'(|n_reg[2]), 32'd0);
        chk("lane3_kept", 32'(n_reg[3][350]), 32'd1);
        @(negedge clk);
        chk("hit_one_cycle", 32'(hit), 32'd0);

        @(posedge clk); #1 press = 4'b0100;
        @(posedge clk); #1 press = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bad_lane2", 32'(bad), 32'b0100);
        chk("bad_no_hit", 32'(hit), 32'd0);

        for (int k = 0; k < 5; k++) do_tick('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, rd1, rd2);
        @(posedge clk); #1;
        chk("miss0_count", 32'(miss0_cnt), 32'd1);
        chk("miss0_tick", 32'(miss0_tick), 32'd180);
        chk("first_miss", 32'(first_miss), 32'b0001);
        chk("empty_after_miss", 32'(|n_reg), 32'd0);

        // Final chart row carries one lane-1 note; play it out.
        do_tick(4'b0010, 1'b1, 1'b1, '0, 1'b1, 1'b0, rd1, rd2);
        chk("last_ready1", 32'(rd1), 32'd1);
        chk("ready_after_last", 32'(rd2), 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 250) begin
            do_tick('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, rd1, rd2);
            n++;
            @(posedge clk); #1;
        end
        chk("done_ticks", 32'(n), 32'd180);
        chk("done_set", 32'(done), 32'd1);
        chk("done_ready", 32'(chart_ready), 32'd0);
        run = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_cleared", 32'(done), 32'd0);

        for (int i = 0; i < 8000; i++) begin
            run         = ($urandom % 20) != 0;
            frame_tick  = ($urandom % 4) == 0;
            chart_valid = ($urandom % 5) != 0;
            chart_row   = 4'($urandom) & 4'($urandom);
            chart_last  = ($urandom % 1500) == 0;
            press       = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            @(posedge clk); #1;
        end

        frame_tick = 1'b0; chart_valid = 1'b0; chart_last = 1'b0; press = '0; run = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; run = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0; chart_valid = 1'b1; chart_row = 4'b1111;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_loaded", 32'(|n_reg), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_nreg", 32'(|n_reg), 32'd0);
        chk("async_rst_ctrl", 32'({chart_ready, busy, done}), 32'd0);
        chk("async_rst_pulses", 32'({hit, bad, miss}), 32'd0);
        @(posedge clk); #1 rst = 1'b0; chart_valid = 1'b0; chart_row = '0; run = 1'b0; frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(chart_ready), 32'd0);
        chk("idle_nreg", 32'(|n_reg), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
